// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and helpers
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Whole sys_clk cycles per bit, truncated; shared with the transmitter.
    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - received-byte output bundle of the UART receiver
interface uart_receiver_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_data_wr;
    logic                      rx_frame_err;
    logic                      rx_busy;

    modport master (
        output rx_data,
        output rx_data_wr,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_data_wr,
        input rx_frame_err,
        input rx_busy
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with selectable reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first one a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive deserializer
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 27_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    input  logic            uart_rx,
    uart_receiver_if.master rx
);

    localparam int BIT_CYCLES  = bit_cycles(CLK_HZ, BAUD);
    localparam int HALF_CYCLES = BIT_CYCLES / 2;

    localparam logic [15:0] BIT_LAST  = 16'(BIT_CYCLES - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CYCLES - 1);
    localparam logic [2:0]  IDX_LAST  = 3'(UART_DATA_BITS - 1);

    if (BIT_CYCLES < 4) begin : g_bad_baud
        $error("uart_receiver: CLK_HZ/BAUD must be at least 4");
    end

    logic rx_s;
    logic rx_d;
    logic fall;

    uart_rx_state_t            state_q, state_d;
    logic [15:0]               cyc_q, cyc_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      wr_q, wr_d;
    logic                      err_q, err_d;
    logic                      busy_q, busy_d;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d     (uart_rx),
        .q     (rx_s)
    );

    // Previous synchronised sample, for start-edge detection.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_d <= 1'b1;
        end else begin
            rx_d <= rx_s;
        end
    end

    // A held-low line never looks like a new edge until it goes high again.
    assign fall = rx_d & ~rx_s;

    // FSM state, counters, shift register and registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: mid-bit sampling driven by the cycle counter.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q + 16'd1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                // Half a bit in: a high line means the edge was a glitch.
                if (cyc_q == HALF_LAST) begin
                    cyc_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d = '0;
                    sh_d  = {rx_s, sh_q[UART_DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is caught.
                if (cyc_q == BIT_LAST) begin
                    cyc_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d = sh_q;
                        wr_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign rx.rx_data      = data_q;
    assign rx.rx_data_wr   = wr_q;
    assign rx.rx_frame_err = err_q;
    assign rx.rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int BIT  = 27_000_000 / 115_200;
    localparam int HALF = BIT / 2;
    localparam int LAT  = 3 + HALF + 9 * BIT;
    localparam int FAST = 228;
    localparam int SLOW = 240;

    typedef struct {
        bit          is_err;
        logic [7:0]  data;
        int unsigned at;
    } ev_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b1;
    logic uart_rx = 1'b1;

    int unsigned cycle = 0;
    int          checks = 0;
    int          failures = 0;
    ev_t         exp_q[$];
    int unsigned wr_times[$];
    logic [7:0]  model_data = 8'h00;

    uart_receiver_if rx_if ();

    uart_receiver dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .uart_rx (uart_rx),
        .rx      (rx_if)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cycle <= cycle + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cycle);
        end
    endtask

    // Compare DUT against the expected-event model on every falling clock edge.
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_data = 8'h00;
            check("reset_outputs",
                  int'({rx_if.rx_data, rx_if.rx_data_wr, rx_if.rx_frame_err, rx_if.rx_busy}), 0);
        end else begin
            if (rx_if.rx_data_wr && rx_if.rx_frame_err) begin
                check("wr_and_err_together", int'({rx_if.rx_data_wr, rx_if.rx_frame_err}), 'b10);
            end
            if (rx_if.rx_data_wr || rx_if.rx_frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'({rx_if.rx_data_wr, rx_if.rx_frame_err}), 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("pulse_is_err", int'(rx_if.rx_frame_err), int'(e.is_err));
                    check_range("pulse_time", int'(cycle), int'(e.at) - 1, int'(e.at) + 1);
                    check("busy_at_pulse", int'(rx_if.rx_busy), 0);
                    if (!e.is_err) model_data = e.data;
                end
                if (rx_if.rx_data_wr) wr_times.push_back(cycle);
            end else if (exp_q.size() != 0 && cycle > exp_q[0].at + 1) begin
                check("missing_pulse_cycle", int'(cycle), int'(exp_q[0].at));
                void'(exp_q.pop_front());
            end
            check("rx_data", int'(rx_if.rx_data), int'(model_data));
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit stop, input int blen,
                              input bit expect_it, output int unsigned start_cyc);
        ev_t e;
        @(posedge sys_clk);
        #1;
        uart_rx   = 1'b0;
        start_cyc = cycle;
        if (expect_it) begin
            e.is_err = !stop;
            e.data   = d;
            e.at     = cycle + LAT;
            exp_q.push_back(e);
        end
        repeat (blen) @(posedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            uart_rx = d[i];
            repeat (blen) @(posedge sys_clk);
        end
        #1;
        uart_rx = stop;
        repeat (blen - 1) @(posedge sys_clk);
    endtask

    initial begin
        int unsigned s0;
        int unsigned s1;
        int          busy_cnt;
        int          n;

        #2 rst_n = 1'b0;
        repeat (4) @(posedge sys_clk);
        #2 rst_n = 1'b1;
        repeat (10) @(posedge sys_clk);

        // 0x55 at nominal baud, latency pinned against the hand-computed value.
        n = wr_times.size();
        send_frame(8'h55, 1'b1, BIT, 1'b1, s0);
        repeat (20) @(posedge sys_clk);
        #1;
        check("w55_count", wr_times.size() - n, 1);
        if (wr_times.size() > n) check_range("w55_latency", int'(wr_times[n] - s0), 2225, 2227);
        check("w55_data", int'(rx_if.rx_data), 'h55);

        // 50-cycle glitch on an idle line.
        busy_cnt = 0;
        n = wr_times.size();
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (i == 0)  uart_rx = 1'b0;
            if (i == 50) uart_rx = 1'b1;
            if (rx_if.rx_busy) busy_cnt++;
        end
        check_range("glitch_busy_cycles", busy_cnt, 1, 119);
        check("glitch_busy_end", int'(rx_if.rx_busy), 0);
        check("glitch_no_wr", wr_times.size() - n, 0);
        check("glitch_data_kept", int'(rx_if.rx_data), 'h55);

        // 0xA3 with a low stop bit, then a 20-bit break, then 0x3C.
        send_frame(8'hA3, 1'b0, BIT, 1'b1, s0);
        n = wr_times.size();
        repeat (20 * BIT) @(posedge sys_clk);
        #1;
        check("break_busy", int'(rx_if.rx_busy), 0);
        check("break_no_wr", wr_times.size() - n, 0);
        check("ferr_data_kept", int'(rx_if.rx_data), 'h55);
        uart_rx = 1'b1;
        repeat (BIT) @(posedge sys_clk);
        send_frame(8'h3C, 1'b1, BIT, 1'b1, s0);
        repeat (20) @(posedge sys_clk);
        #1;
        check("w3c_data", int'(rx_if.rx_data), 'h3C);

        // Back-to-back 0x41, 0x42 with no idle gap.
        n = wr_times.size();
        send_frame(8'h41, 1'b1, BIT, 1'b1, s0);
        send_frame(8'h42, 1'b1, BIT, 1'b1, s1);
        repeat (20) @(posedge sys_clk);
        #1;
        check("b2b_count", wr_times.size() - n, 2);
        if (wr_times.size() >= n + 2)
            check_range("b2b_spacing", int'(wr_times[n+1] - wr_times[n]), 2339, 2341);
        check("b2b_last_data", int'(rx_if.rx_data), 'h42);

        // Reset asserted during bit 4 of 0x7E.
        @(posedge sys_clk);
        #1;
        uart_rx = 1'b0;
        repeat (BIT) @(posedge sys_clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            uart_rx = (8'h7E >> i) & 8'h01;
            if (i < 4) repeat (BIT) @(posedge sys_clk);
        end
        repeat (100) @(posedge sys_clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              int'({rx_if.rx_data, rx_if.rx_data_wr, rx_if.rx_frame_err, rx_if.rx_busy}), 0);
        uart_rx = 1'b1;
        repeat (20) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (50) @(posedge sys_clk);
        send_frame(8'h81, 1'b1, BIT, 1'b1, s0);
        repeat (20) @(posedge sys_clk);
        #1;
        check("w81_data", int'(rx_if.rx_data), 'h81);

        // Baud +2.5% then -2.5%.
        n = wr_times.size();
        send_frame(8'hFF, 1'b1, FAST, 1'b1, s0);
        send_frame(8'h00, 1'b1, FAST, 1'b1, s0);
        send_frame(8'hFF, 1'b1, SLOW, 1'b1, s0);
        send_frame(8'h00, 1'b1, SLOW, 1'b1, s0);
        repeat (300) @(posedge sys_clk);
        #1;
        check("skew_count", wr_times.size() - n, 4);
        check("skew_last_data", int'(rx_if.rx_data), 'h00);
        check("expected_all_seen", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
